// File: rtl/readout_pkg.sv
// Shared readout types and defaults for the pixel bus, frame FSM and readout controller.
// Optional parity output is enabled in the controller by READOUT_PARITY_EN.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OUTPUT,
    DONE
  } state_e;

  localparam int NUM_ROWS_DEF = 2;
  localparam int DATA_W_DEF   = 16;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readout_settle_timer.sv
// Loadable down-counter holding a row select for SETTLE_CYCLES+1 cycles.
// expire marks the last select cycle, when the bus word is captured.
module readout_settle_timer
  import readout_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = cnt_w(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(SETTLE_CYCLES);
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Pixel frame readout: one-hot row select, settle, capture, valid/ready offer.
// Define READOUT_PARITY_EN to add the registered out_parity output.
module pixel_readout_ctrl
  import readout_pkg::*;
#(
  parameter int NUM_ROWS      = NUM_ROWS_DEF,
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = DATA_W_DEF,
  localparam int ROW_W        = cnt_w(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [NUM_ROWS-1:0] read_sel,
  input  logic [DATA_W-1:0] bus_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef READOUT_PARITY_EN
  output logic              out_parity,
`endif
  output logic              frame_done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ROW_W-1:0]  orow_q, orow_d;
  logic              load;
  logic              expire;

  readout_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .en_i    (state_q == SELECT),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    data_d  = data_q;
    orow_d  = orow_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SELECT;
          row_d   = '0;
          load    = 1'b1;
        end
      end
      SELECT: begin
        if (expire) begin
          state_d = OUTPUT;
          data_d  = bus_data;
          orow_d  = row_q;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            state_d = SELECT;
            row_d   = row_q + 1'b1;
            load    = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      data_q  <= '0;
      orow_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      data_q  <= data_d;
      orow_q  <= orow_d;
    end
  end

`ifdef READOUT_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (state_q == SELECT && expire) begin
      par_d = ^bus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q;
`endif

  assign read_sel   = (state_q == SELECT) ? (NUM_ROWS'(1) << row_q) : '0;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == OUTPUT);
  assign frame_done = (state_q == DONE);
  assign out_data   = data_q;
  assign out_row    = orow_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl (NUM_ROWS=2, SETTLE_CYCLES=1).
module tb_pixel_readout_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic [1:0]  read_sel;
  logic [15:0] bus_data;
  logic [15:0] out_data;
  logic [0:0]  out_row;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
`ifdef READOUT_PARITY_EN
  logic        out_parity;
`endif

  int n_pass;
  int n_total;

  pixel_readout_ctrl #(
    .NUM_ROWS     (2),
    .SETTLE_CYCLES(1),
    .DATA_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .read_sel  (read_sel),
    .bus_data  (bus_data),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef READOUT_PARITY_EN
    .out_parity(out_parity),
`endif
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({busy, read_sel, out_valid, out_data, out_row, frame_done} !== 21'd0)
        $display("FAIL reset_cyc%0d: busy=%b sel=%b vld=%b data=%h row=%b done=%b, need all 0",
                 i, busy, read_sel, out_valid, out_data, out_row, frame_done);
      else n_pass++;
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    out_ready = 1'b1;
    bus_data  = 16'hA55A;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (read_sel !== 2'b01 || busy !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL nom_sel0_%0d: sel=%b busy=%b vld=%b, need 01 1 0",
                 i, read_sel, busy, out_valid);
      else n_pass++;
      step();
    end
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'hA55A || out_row !== 1'b0 || read_sel !== 2'b00)
      $display("FAIL nom_out0: vld=%b data=%h row=%b sel=%b, need 1 a55a 0 00",
               out_valid, out_data, out_row, read_sel);
    else n_pass++;
    bus_data = 16'h1234;
    step();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (read_sel !== 2'b10 || out_valid !== 1'b0)
        $display("FAIL nom_sel1_%0d: sel=%b vld=%b, need 10 0", i, read_sel, out_valid);
      else n_pass++;
      step();
    end
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_row !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL nom_out1: vld=%b data=%h row=%b done=%b, need 1 1234 1 0",
               out_valid, out_data, out_row, frame_done);
    else n_pass++;
    step();
    n_total++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || read_sel !== 2'b00)
      $display("FAIL nom_done: done=%b busy=%b vld=%b sel=%b, need 1 1 0 00",
               frame_done, busy, out_valid, read_sel);
    else n_pass++;
    step();
    n_total++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL nom_idle: done=%b busy=%b, need 0 0", frame_done, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    bus_data  = 16'h5A0F;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    bus_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 16'h5A0F || out_row !== 1'b0 || read_sel !== 2'b00)
        $display("FAIL bp_stall%0d: vld=%b data=%h row=%b sel=%b, need 1 5a0f 0 00",
                 i, out_valid, out_data, out_row, read_sel);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    step();
    n_total++;
    if (read_sel !== 2'b10 || out_valid !== 1'b0)
      $display("FAIL bp_resume: sel=%b vld=%b, need 10 0", read_sel, out_valid);
    else n_pass++;
    step();
    step();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_row !== 1'b1)
      $display("FAIL bp_out1: vld=%b data=%h row=%b, need 1 ffff 1", out_valid, out_data, out_row);
    else n_pass++;
    step();
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL bp_idle: busy=%b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int words;
    int dones;
    int bad_sel;
    bit seen;
    words   = 0;
    dones   = 0;
    bad_sel = 0;
    seen    = 1'b0;
    out_ready = 1'b1;
    bus_data  = 16'h0F0F;
    start     = 1'b1;
    step();
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid && out_ready) words++;
      if ($countones(read_sel) > 1) bad_sel++;
      if (frame_done) begin
        dones++;
        seen  = 1'b1;
        start = 1'b0;
      end
      step();
    end
    n_total++;
    if (!seen) $display("FAIL si_timeout: frame_done=0 need 1 within 20 cycles");
    else n_pass++;
    n_total++;
    if (words !== 2 || dones !== 1)
      $display("FAIL si_count: words=%0d dones=%0d, need 2 1", words, dones);
    else n_pass++;
    n_total++;
    if (bad_sel !== 0) $display("FAIL si_onehot: bad=%0d need 0", bad_sel);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL si_idle: busy=%b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    bus_data  = 16'hBEEF;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    n_total++;
    if (read_sel !== 2'b10) $display("FAIL rm_sel1: sel=%b need 10", read_sel);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if (read_sel !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0)
      $display("FAIL rm_abort: sel=%b busy=%b vld=%b data=%h, need 00 0 0 0000",
               read_sel, busy, out_valid, out_data);
    else n_pass++;
    reset = 1'b1;
    step();
    step();
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rm_idle: busy=%b vld=%b, need 0 0", busy, out_valid);
    else n_pass++;
  endtask

`ifdef READOUT_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    bus_data  = 16'h0007;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_total++;
    if (out_parity !== 1'b1) $display("FAIL par_0007: par=%b need 1", out_parity);
    else n_pass++;
    bus_data = 16'h0003;
    step();
    step();
    step();
    n_total++;
    if (out_parity !== 1'b0) $display("FAIL par_0003: par=%b need 0", out_parity);
    else n_pass++;
    step();
    step();
  endtask
`endif

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    start     = 1'b0;
    bus_data  = 16'h0;
    out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
`ifdef READOUT_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
